// File: rtl/ps2_receptor.sv
`timescale 1ns/1ps
// ps2_receptor
//   PS/2 keyboard serial receiver feeding the scancode filter.
//   Both PS/2 lines are synchronised; ps2c is additionally deglitched
//   through a FILTER_LEN-deep shift register. Each 11-bit frame
//   (start, 8 data LSB-first, odd parity, stop) is deserialised on the
//   falling edges of the filtered clock and checked. A good frame
//   updates dout and pulses rx_done_tick. A bad or stalled frame
//   pulses err_tick.
//
// Ports
//   clk           system clock, all logic on posedge
//   reset         asynchronous, active-high reset
//   ps2c, ps2d    PS/2 clock / data lines (asynchronous, idle high)
//   rx_en         1 = a start bit may open a new frame
//   rx_done_tick  1-cycle pulse, dout holds a newly received byte
//   dout          last valid received byte
//   err_tick      1-cycle pulse, frame discarded (parity/stop/timeout)
module ps2_receptor #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       err_tick
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, DPS, CHK} state_t;

    // ------------------------------------------------------------------
    // Input path: 2-FF synchronisers, then the ps2c deglitch filter.
    // Everything resets to the idle-high level so that leaving reset
    // never manufactures a falling edge.
    // ------------------------------------------------------------------
    logic [1:0]            c_sync_reg;
    logic [1:0]            d_sync_reg;
    logic [FILTER_LEN-1:0] filt_reg;
    logic                  level_reg;
    logic                  level_prev_reg;
    logic                  fall_edge;
    logic                  d_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_sync_reg <= 2'b11;
            d_sync_reg <= 2'b11;
        end else begin
            c_sync_reg <= {c_sync_reg[0], ps2c};
            d_sync_reg <= {d_sync_reg[0], ps2d};
        end
    end

    generate
        for (genvar gi = 0; gi < FILTER_LEN; gi++) begin : g_filt
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) filt_reg[gi] <= 1'b1;
                    else       filt_reg[gi] <= c_sync_reg[1];
                end
            end else begin : g_tail
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) filt_reg[gi] <= 1'b1;
                    else       filt_reg[gi] <= filt_reg[gi-1];
                end
            end
        end
    endgenerate

    // Level changes only on a unanimous window; mixed windows hold,
    // so pulses shorter than FILTER_LEN cycles never reach the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_reg      <= 1'b1;
            level_prev_reg <= 1'b1;
        end else begin
            if (&filt_reg)
                level_reg <= 1'b1;
            else if (~|filt_reg)
                level_reg <= 1'b0;
            level_prev_reg <= level_reg;
        end
    end

    assign fall_edge = level_prev_reg & ~level_reg;
    assign d_in      = d_sync_reg[1];

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t       state_reg, state_next;
    logic [10:0]  sr_reg, sr_next;
    logic [3:0]   bit_reg, bit_next;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic [7:0]   dout_reg, dout_next;
    logic         done_reg, done_next;
    logic         err_reg, err_next;
    logic         frame_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            sr_reg    <= '0;
            bit_reg   <= '0;
            tmo_reg   <= '0;
            dout_reg  <= 8'h00;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sr_reg    <= sr_next;
            bit_reg   <= bit_next;
            tmo_reg   <= tmo_next;
            dout_reg  <= dout_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    // After all 11 shifts: sr[0]=start, sr[8:1]=data, sr[9]=parity,
    // sr[10]=stop. Odd parity means data plus parity has odd weight.
    assign frame_ok = sr_reg[10] & ~sr_reg[0] & (^sr_reg[9:1]);

    always_comb begin
        state_next = state_reg;
        sr_next    = sr_reg;
        bit_next   = bit_reg;
        tmo_next   = tmo_reg;
        dout_next  = dout_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fall_edge && rx_en && !d_in) begin
                    state_next = DPS;
                    bit_next   = 4'd9;
                    tmo_next   = '0;
                    sr_next    = {d_in, sr_reg[10:1]};
                end
            end
            DPS: begin
                if (fall_edge) begin
                    sr_next  = {d_in, sr_reg[10:1]};
                    tmo_next = '0;
                    if (bit_reg == 4'd0)
                        state_next = CHK;
                    else
                        bit_next = bit_reg - 4'd1;
                end else if (tmo_reg == TMO_MAX) begin
                    // Sender stalled mid-frame: drop it.
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            CHK: begin
                state_next = IDLE;
                if (frame_ok) begin
                    dout_next = sr_reg[8:1];
                    done_next = 1'b1;
                end else begin
                    err_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rx_done_tick = done_reg;
    assign err_tick     = err_reg;
    assign dout         = dout_reg;

endmodule

// File: tb/tb_ps2_receptor.sv
`timescale 1ns/1ps
module tb_ps2_receptor;

    localparam int FLEN = 8;
    localparam int TMO  = 1000;
    localparam int HALF = 40;   // clk cycles per PS/2 clock half-period

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2c;
    logic       ps2d;
    logic       rx_en;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       err_tick;

    int errors = 0;
    int checks = 0;
    int rx_count = 0;
    int err_count = 0;
    logic [7:0] exp_q[$];

    ps2_receptor #(.FILTER_LEN(FLEN), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk),
        .reset(reset),
        .ps2c(ps2c),
        .ps2d(ps2d),
        .rx_en(rx_en),
        .rx_done_tick(rx_done_tick),
        .dout(dout),
        .err_tick(err_tick)
    );

    always #5 clk = ~clk;

    // Scoreboard: every received byte is popped and compared.
    always @(negedge clk) begin
        if (rx_done_tick && err_tick) begin
            checks++;
            errors++;
            $display("FAIL tick_exclusive: rx_done_tick=1 and err_tick=1 together, required not both");
        end
        if (rx_done_tick) begin
            rx_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: got dout=%02h, required no rx_done_tick", dout);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    errors++;
                    $display("FAIL byte: got dout=%02h, required %02h", dout, e);
                end else
                    $display("rx byte %02h ok", dout);
            end
        end
        if (err_tick) begin
            err_count++;
            $display("err_tick seen");
        end
    end

    function automatic logic [10:0] make_frame(input logic [7:0] data,
                                               input logic par_ok,
                                               input logic stop);
        logic par;
        par = par_ok ? ~(^data) : (^data);
        return {stop, par, data, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2d = f[i];
            repeat (HALF) @(posedge clk);
            ps2c = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
    endtask

    task automatic settle();
        repeat (60) @(posedge clk);
        @(negedge clk);
    endtask

    // Common post-scenario checks: pulse counts, pending bytes, dout.
    task automatic check_after(input string name, input int rx0, input int e0,
                               input int rx_exp, input int err_exp,
                               input logic [7:0] dout_exp);
        checks++;
        if (rx_count - rx0 !== rx_exp) begin
            errors++;
            $display("FAIL %s_rx_count: got %0d, required %0d", name, rx_count - rx0, rx_exp);
        end
        checks++;
        if (err_count - e0 !== err_exp) begin
            errors++;
            $display("FAIL %s_err_count: got %0d, required %0d", name, err_count - e0, err_exp);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d bytes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (dout !== dout_exp) begin
            errors++;
            $display("FAIL %s_dout: got %02h, required %02h", name, dout, dout_exp);
        end
        $display("%s done", name);
    endtask

    task automatic test_reset();
        reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({rx_done_tick, err_tick, dout} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got done=%b err=%b dout=%02h, required 0/0/00",
                     rx_done_tick, err_tick, dout);
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_after("reset_idle", 0, 0, 0, 0, 8'h00);
    endtask

    task automatic test_single();
        int rx0 = rx_count, e0 = err_count;
        exp_q.push_back(8'h1C);
        send_bits(make_frame(8'h1C, 1'b1, 1'b1), 11);
        settle();
        check_after("single_1C", rx0, e0, 1, 0, 8'h1C);
    endtask

    task automatic test_back_to_back();
        int rx0 = rx_count, e0 = err_count;
        exp_q.push_back(8'hF0);
        send_bits(make_frame(8'hF0, 1'b1, 1'b1), 11);
        exp_q.push_back(8'h1C);
        send_bits(make_frame(8'h1C, 1'b1, 1'b1), 11);
        settle();
        check_after("b2b_F0_1C", rx0, e0, 2, 0, 8'h1C);
    endtask

    task automatic test_bad_frames();
        int rx0 = rx_count, e0 = err_count;
        send_bits(make_frame(8'h24, 1'b0, 1'b1), 11);
        settle();
        check_after("bad_parity", rx0, e0, 0, 1, 8'h1C);
        rx0 = rx_count; e0 = err_count;
        send_bits(make_frame(8'h1C, 1'b1, 1'b0), 11);
        settle();
        check_after("bad_stop", rx0, e0, 0, 1, 8'h1C);
    endtask

    task automatic test_glitch();
        int rx0 = rx_count, e0 = err_count;
        ps2c = 1'b0;
        repeat (3) @(posedge clk);
        ps2c = 1'b1;
        settle();
        check_after("glitch", rx0, e0, 0, 0, 8'h1C);
        rx0 = rx_count; e0 = err_count;
        exp_q.push_back(8'h4D);
        send_bits(make_frame(8'h4D, 1'b1, 1'b1), 11);
        settle();
        check_after("after_glitch_4D", rx0, e0, 1, 0, 8'h4D);
    endtask

    task automatic test_timeout();
        int rx0 = rx_count, e0 = err_count;
        send_bits(make_frame(8'h55, 1'b1, 1'b1), 5);
        repeat (TMO + 100) @(posedge clk);
        @(negedge clk);
        check_after("timeout", rx0, e0, 0, 1, 8'h4D);
        rx0 = rx_count; e0 = err_count;
        exp_q.push_back(8'h24);
        send_bits(make_frame(8'h24, 1'b1, 1'b1), 11);
        settle();
        check_after("after_timeout_24", rx0, e0, 1, 0, 8'h24);
    endtask

    task automatic test_reset_mid_frame();
        int rx0 = rx_count, e0 = err_count;
        send_bits(make_frame(8'hA7, 1'b1, 1'b1), 5);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        settle();
        check_after("reset_mid", rx0, e0, 0, 0, 8'h00);
        rx0 = rx_count; e0 = err_count;
        exp_q.push_back(8'h1B);
        send_bits(make_frame(8'h1B, 1'b1, 1'b1), 11);
        settle();
        check_after("after_reset_1B", rx0, e0, 1, 0, 8'h1B);
    endtask

    task automatic test_rx_disabled();
        int rx0 = rx_count, e0 = err_count;
        rx_en = 1'b0;
        send_bits(make_frame(8'h33, 1'b1, 1'b1), 11);
        settle();
        rx_en = 1'b1;
        check_after("rx_disabled", rx0, e0, 0, 0, 8'h1B);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_frames();
        test_glitch();
        test_timeout();
        test_reset_mid_frame();
        test_rx_disabled();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
